// File: rtl/mem_map_ctrl_if.sv
// CPU/VIC bus view of the memory-map controller: address, cartridge and port-pin inputs, registered selects out.
interface mem_map_ctrl_if #(parameter int IO_SLOTS = 4);
    logic                cpu_en;
    logic [15:0]         a;
    logic                r_w;
    logic [7:0]          din;
    logic                aec_n;
    logic                ba;
    logic                va12;
    logic                va13;
    logic                va14_n;
    logic                game_n;
    logic                exrom_n;
    logic [7:0]          ext_in;
    logic [7:0]          port_out;
    logic                port_rd;
    logic [7:0]          dout;
    logic                romh;
    logic                roml;
    logic                kernal;
    logic                basic;
    logic                charom;
    logic                io;
    logic                vic;
    logic                sid;
    logic                color_ram;
    logic                gr_w;
    logic                casram;
    logic [IO_SLOTS-1:0] io_cs;

    modport master (
        output cpu_en, a, r_w, din, aec_n, ba, va12, va13, va14_n, game_n, exrom_n, ext_in,
        input  port_out, port_rd, dout, romh, roml, kernal, basic, charom, io, vic, sid,
               color_ram, gr_w, casram, io_cs
    );

    modport slave (
        input  cpu_en, a, r_w, din, aec_n, ba, va12, va13, va14_n, game_n, exrom_n, ext_in,
        output port_out, port_rd, dout, romh, roml, kernal, basic, charom, io, vic, sid,
               color_ram, gr_w, casram, io_cs
    );
endinterface

// File: rtl/mem_map_ctrl.sv
// 6510 processor port with bit decay plus a registered CPU/VIC address decoder.
// Selects are valid one clock after a sample (cpu_en or aec_n) and hold until the next one; no backpressure.
module mem_map_ctrl #(
    parameter int         IO_SLOTS     = 4,
    parameter int         DECAY_CYCLES = 350000,
    parameter logic [7:0] DECAY_MASK   = 8'hC0
) (
    input logic          clk,
    input logic          reset_n,
    mem_map_ctrl_if.slave bus
);
    localparam int CW = $clog2(DECAY_CYCLES + 1);
    localparam int SW = $clog2(IO_SLOTS);

    logic [7:0]    ddr;
    logic [7:0]    data;
    logic [7:0]    held;
    logic [CW-1:0] cnt [8];
    logic [7:0]    undrv;
    logic [7:0]    port_out;

    logic          loram, hiram, charen, ultimax, rd;
    logic [3:0]    nib;
    logic [9:0]    slot;

    logic          romh_d, roml_d, kernal_d, basic_d, charom_d, io_d;
    logic          vic_d, sid_d, color_ram_d, gr_w_d, casram_d;
    logic [IO_SLOTS-1:0] io_cs_d;

    // Only DECAY_MASK bits use the held/counter state; the rest follow the external pull-ups.
    assign undrv    = (held & DECAY_MASK) | (bus.ext_in & ~DECAY_MASK);
    assign port_out = (ddr & data) | (~ddr & undrv);

    assign bus.port_out = port_out;
    assign bus.port_rd  = bus.r_w && (bus.a[15:1] == 15'd0);
    assign bus.dout     = bus.a[0] ? port_out : ddr;

    assign loram   = port_out[0];
    assign hiram   = port_out[1];
    assign charen  = port_out[2];
    assign ultimax = bus.exrom_n && !bus.game_n;
    assign rd      = bus.r_w;
    assign nib     = bus.a[15:12];
    assign slot    = bus.a[9:0] >> (10 - SW);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ddr  <= 8'h00;
            data <= 8'h00;
        end else if (bus.cpu_en && !bus.r_w && (bus.a == 16'h0000)) begin
            ddr <= bus.din;
        end else if (bus.cpu_en && !bus.r_w && (bus.a == 16'h0001)) begin
            data <= bus.din;
        end
    end

    // Held level only clears on the 1->0 counter transition, so a fresh reset keeps reading 1.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (!reset_n) begin
                held[i] <= 1'b1;
                cnt[i]  <= '0;
            end else if (ddr[i]) begin
                held[i] <= data[i];
                cnt[i]  <= CW'(DECAY_CYCLES);
            end else if (cnt[i] != '0) begin
                cnt[i] <= cnt[i] - CW'(1);
                if (cnt[i] == CW'(1))
                    held[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        romh_d      = 1'b0;
        roml_d      = 1'b0;
        kernal_d    = 1'b0;
        basic_d     = 1'b0;
        charom_d    = 1'b0;
        io_d        = 1'b0;
        vic_d       = 1'b0;
        sid_d       = 1'b0;
        color_ram_d = 1'b0;
        gr_w_d      = 1'b0;
        casram_d    = 1'b0;
        io_cs_d     = '0;
        if (bus.aec_n) begin
            if (ultimax && bus.va13 && bus.va12)
                romh_d = 1'b1;
            else if (bus.va14_n && !bus.va13 && bus.va12 && !ultimax)
                charom_d = 1'b1;
            else
                casram_d = 1'b1;
        end else begin
            basic_d  = (nib == 4'hA || nib == 4'hB) && rd && loram && hiram && bus.game_n;
            kernal_d = (nib >= 4'hE) && rd && hiram && !ultimax;
            roml_d   = (nib == 4'h8 || nib == 4'h9) &&
                       ((rd && loram && hiram && !bus.exrom_n) || ultimax);
            romh_d   = ((nib == 4'hA || nib == 4'hB) && rd && hiram && !bus.exrom_n && !bus.game_n) ||
                       ((nib >= 4'hE) && ultimax);
            charom_d = (nib == 4'hD) && rd && !charen && (loram || hiram) && !ultimax;
            io_d     = (nib == 4'hD) && ((charen && (loram || hiram)) || ultimax) &&
                       (bus.ba || !rd);
            if (io_d) begin
                case (bus.a[11:10])
                    2'b00:   vic_d       = 1'b1;
                    2'b01:   sid_d       = 1'b1;
                    2'b10:   color_ram_d = 1'b1;
                    default: io_cs_d     = IO_SLOTS'(1) << slot;
                endcase
            end
            gr_w_d   = io_d && color_ram_d && !rd;
            // Ultimax leaves $1000-$7FFF and $A000-$CFFF open for the cartridge.
            casram_d = !(romh_d || roml_d || kernal_d || basic_d || charom_d || io_d) &&
                       !(ultimax && ((nib >= 4'h1 && nib <= 4'h7) || (nib >= 4'hA && nib <= 4'hC)));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.romh      <= 1'b0;
            bus.roml      <= 1'b0;
            bus.kernal    <= 1'b0;
            bus.basic     <= 1'b0;
            bus.charom    <= 1'b0;
            bus.io        <= 1'b0;
            bus.vic       <= 1'b0;
            bus.sid       <= 1'b0;
            bus.color_ram <= 1'b0;
            bus.gr_w      <= 1'b0;
            bus.casram    <= 1'b0;
            bus.io_cs     <= '0;
        end else if (bus.cpu_en || bus.aec_n) begin
            bus.romh      <= romh_d;
            bus.roml      <= roml_d;
            bus.kernal    <= kernal_d;
            bus.basic     <= basic_d;
            bus.charom    <= charom_d;
            bus.io        <= io_d;
            bus.vic       <= vic_d;
            bus.sid       <= sid_d;
            bus.color_ram <= color_ram_d;
            bus.gr_w      <= gr_w_d;
            bus.casram    <= casram_d;
            bus.io_cs     <= io_cs_d;
        end
    end
endmodule

// File: tb/tb_mem_map_ctrl.sv
// Directed vectors for mem_map_ctrl with a short decay window and eight I/O slots.
module tb_mem_map_ctrl;
    localparam int SLOTS = 8;
    localparam int DEC   = 20;

    localparam logic [10:0] S_ROMH   = 11'b100_0000_0000;
    localparam logic [10:0] S_ROML   = 11'b010_0000_0000;
    localparam logic [10:0] S_KERNAL = 11'b001_0000_0000;
    localparam logic [10:0] S_BASIC  = 11'b000_1000_0000;
    localparam logic [10:0] S_CHAROM = 11'b000_0100_0000;
    localparam logic [10:0] S_IO     = 11'b000_0010_0000;
    localparam logic [10:0] S_VIC    = 11'b000_0001_0000;
    localparam logic [10:0] S_SID    = 11'b000_0000_1000;
    localparam logic [10:0] S_COL    = 11'b000_0000_0100;
    localparam logic [10:0] S_GRW    = 11'b000_0000_0010;
    localparam logic [10:0] S_CAS    = 11'b000_0000_0001;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;
    int   n;

    always #5 clk = ~clk;

    mem_map_ctrl_if #(.IO_SLOTS(SLOTS)) bus ();

    mem_map_ctrl #(.IO_SLOTS(SLOTS), .DECAY_CYCLES(DEC), .DECAY_MASK(8'hC0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [10:0] sel;
    assign sel = {bus.romh, bus.roml, bus.kernal, bus.basic, bus.charom, bus.io,
                  bus.vic, bus.sid, bus.color_ram, bus.gr_w, bus.casram};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [15:0] addr, input logic rw, input logic [7:0] d);
        bus.a      = addr;
        bus.r_w    = rw;
        bus.din    = d;
        bus.cpu_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cpu_en = 1'b0;
        bus.r_w    = 1'b1;
    endtask

    task automatic vcyc(input logic v14n, input logic v13, input logic v12);
        bus.va14_n = v14n;
        bus.va13   = v13;
        bus.va12   = v12;
        bus.aec_n  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.aec_n  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.cpu_en = 1'b0; bus.a = 16'h0000; bus.r_w = 1'b1; bus.din = 8'h00;
        bus.aec_n = 1'b0; bus.ba = 1'b1; bus.va12 = 1'b0; bus.va13 = 1'b0; bus.va14_n = 1'b0;
        bus.game_n = 1'b1; bus.exrom_n = 1'b1; bus.ext_in = 8'hDF;

        repeat (3) @(negedge clk);
        check("rst_sel", 32'(sel), 32'(0));
        check("rst_iocs", 32'(bus.io_cs), 32'(0));
        check("rst_port", 32'(bus.port_out), 32'hDF);
        reset_n = 1'b1;

        cyc(16'hA000, 1'b1, 8'h00);  check("t1_basic", 32'(sel), 32'(S_BASIC));
        bus.a = 16'h0001; #1;
        check("t1_port_rd", 32'(bus.port_rd), 32'(1));
        check("t1_dout", 32'(bus.dout), 32'hDF);

        cyc(16'h0000, 1'b0, 8'h07);  check("t2_ddr_wr_cas", 32'(sel), 32'(S_CAS));
        cyc(16'h0001, 1'b0, 8'h35);  check("t2_port", 32'(bus.port_out), 32'hDD);
        bus.a = 16'h0000; #1;        check("t2_ddr_rd", 32'(bus.dout), 32'h07);
        cyc(16'hD000, 1'b1, 8'h00);  check("t2_vic", 32'(sel), 32'(S_IO | S_VIC));
        cyc(16'hA000, 1'b1, 8'h00);  check("t2_a000_ram", 32'(sel), 32'(S_CAS));
        cyc(16'hD800, 1'b0, 8'h5A);  check("t2_color_wr", 32'(sel), 32'(S_IO | S_COL | S_GRW));
        cyc(16'hD400, 1'b1, 8'h00);  check("t2_sid", 32'(sel), 32'(S_IO | S_SID));
        cyc(16'hDD80, 1'b1, 8'h00);  check("t6_dd80_sel", 32'(sel), 32'(S_IO));
        check("t6_dd80_cs", 32'(bus.io_cs), 32'h08);
        cyc(16'hDC00, 1'b1, 8'h00);  check("t6_dc00_cs", 32'(bus.io_cs), 32'h01);
        bus.ba = 1'b0;
        cyc(16'hD000, 1'b1, 8'h00);  check("ba_low_rd", 32'(sel), 32'(S_CAS));
        cyc(16'hD000, 1'b0, 8'h00);  check("ba_low_wr", 32'(sel), 32'(S_IO | S_VIC));
        bus.ba = 1'b1;

        cyc(16'h0001, 1'b0, 8'h34);
        cyc(16'hD000, 1'b1, 8'h00);  check("t3_all_ram", 32'(sel), 32'(S_CAS));
        cyc(16'h0001, 1'b0, 8'h37);
        cyc(16'hE000, 1'b1, 8'h00);  check("kernal", 32'(sel), 32'(S_KERNAL));
        cyc(16'h0001, 1'b0, 8'h33);
        cyc(16'hD000, 1'b1, 8'h00);  check("charom_rd", 32'(sel), 32'(S_CHAROM));
        cyc(16'hD000, 1'b0, 8'h00);  check("charom_wr_ram", 32'(sel), 32'(S_CAS));
        cyc(16'h0001, 1'b0, 8'h37);

        bus.exrom_n = 1'b0;
        cyc(16'h8000, 1'b1, 8'h00);  check("roml_8k", 32'(sel), 32'(S_ROML));
        bus.game_n = 1'b0;
        cyc(16'hA000, 1'b1, 8'h00);  check("romh_16k", 32'(sel), 32'(S_ROMH));
        bus.exrom_n = 1'b1;
        cyc(16'hE000, 1'b1, 8'h00);  check("t4_ultimax_e000", 32'(sel), 32'(S_ROMH));
        cyc(16'h4000, 1'b1, 8'h00);  check("t4_ultimax_hole", 32'(sel), 32'(0));
        cyc(16'h8000, 1'b0, 8'h00);  check("ultimax_roml_wr", 32'(sel), 32'(S_ROML));
        cyc(16'hD020, 1'b1, 8'h00);  check("ultimax_io", 32'(sel), 32'(S_IO | S_VIC));
        cyc(16'h0800, 1'b1, 8'h00);  check("ultimax_low_ram", 32'(sel), 32'(S_CAS));
        vcyc(1'b0, 1'b1, 1'b1);      check("vic_ultimax_romh", 32'(sel), 32'(S_ROMH));
        bus.game_n = 1'b1;
        vcyc(1'b1, 1'b0, 1'b1);      check("vic_charom", 32'(sel), 32'(S_CHAROM));
        bus.a = 16'hE000;
        repeat (3) @(negedge clk);
        check("hold_no_sample", 32'(sel), 32'(S_CHAROM));
        vcyc(1'b1, 1'b0, 1'b0);      check("vic_ram", 32'(sel), 32'(S_CAS));

        cyc(16'h0001, 1'b0, 8'hC7);
        cyc(16'h0000, 1'b0, 8'hC7);  check("t5_driven", 32'(bus.port_out), 32'hDF);
        cyc(16'h0000, 1'b0, 8'h07);
        n = 0;
        while (bus.port_out[7] && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("t5_decay_len", 32'(n), 32'(DEC));
        bus.a = 16'h0001; #1;        check("t5_decayed_dout", 32'(bus.dout), 32'h1F);

        cyc(16'h0000, 1'b0, 8'hC7);
        cyc(16'h0000, 1'b0, 8'h07);
        repeat (5) @(negedge clk);
        check("t5_mid_decay", 32'(bus.port_out[7]), 32'(1));
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("t5_rst_port", 32'(bus.port_out), 32'hDF);
        check("t5_rst_sel", 32'(sel), 32'(0));
        cyc(16'h0001, 1'b0, 8'h00);  check("data_wr_no_held", 32'(bus.port_out), 32'hDF);
        repeat (DEC + 10) @(negedge clk);
        check("rst_no_decay", 32'(bus.port_out), 32'hDF);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
